// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//
// Purpose: groups the request/response handshake between the execute stage and
// the load/store unit, and the doubleword data-memory bus, into one bundle.
//
// Modports:
//   slave  : the load/store unit itself (takes requests, drives memory)
//   master : the requester (execute stage); drives req_*, observes resp_*
//   memory : the 64-bit doubleword data memory; observes mem_*, drives readData
//
// Signals:
//   req_valid / req_ready   request handshake, accepted when both are high
//   req_write               1 = store, 0 = load
//   req_funct3              RISC-V funct3 access width / signedness
//   req_addr / req_wdata    byte address and store data
//   resp_valid              one-cycle response pulse, no backpressure
//   resp_rdata / resp_fault load result (0 for stores/faults), fault flag
//   mem_address             doubleword-aligned address during an access
//   mem_writeData           doubleword written on mem_MemWrite
//   mem_MemWrite/MemRead    memory strobes
//   mem_readData            read data, valid one cycle after mem_MemRead
// -----------------------------------------------------------------------------
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_fault;
   logic [63:0] mem_address;
   logic [63:0] mem_writeData;
   logic        mem_MemWrite;
   logic        mem_MemRead;
   logic [63:0] mem_readData;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_readData,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             mem_address, mem_writeData, mem_MemWrite, mem_MemRead
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );

   modport memory (
      input  mem_address, mem_writeData, mem_MemWrite, mem_MemRead,
      output mem_readData
   );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose: converts RV64 byte/half/word/double loads and stores into aligned
// doubleword accesses to a 1-cycle synchronous-read data memory. Loads extract
// the addressed lane and sign/zero-extend it; sub-doubleword stores perform a
// read-modify-write; misaligned, out-of-range or illegal requests produce a
// fault response without touching memory.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of load_store_unit_if (request, response, memory)
//   stat_loads / stat_stores / stat_faults  out [31:0]  saturating response
//          counters, present only when LSU_STATS_EN is defined
//
// Parameters:
//   ADDR_LIMIT  first invalid byte address (requests at or above it fault)
//   MEM_RD_LAT  memory read latency; only 1 is supported
//
// Build option: define LSU_STATS_EN to add the response statistics counters.
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter logic [63:0] ADDR_LIMIT = 64'h2000,
   parameter int          MEM_RD_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   load_store_unit_if.slave   bus
`ifdef LSU_STATS_EN
   ,
   output logic [31:0]        stat_loads,
   output logic [31:0]        stat_stores,
   output logic [31:0]        stat_faults
`endif
);

   generate
      if (MEM_RD_LAT != 1) begin : g_bad_rd_lat
         $error("load_store_unit: MEM_RD_LAT must be 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_FLT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] addr_q;
   logic [2:0]  funct3_q;
   logic        write_q;
   logic [63:0] wdata_q;    // store data, replaced by the merged doubleword in CAP
   logic [63:0] rdata_q;
   logic        fault_q;

   logic        accept;
   logic        misalign;
   logic        req_fault;
   logic [63:0] lane;
   logic [63:0] load_val;
   logic [7:0]  size_be;
   logic [7:0]  byte_en;
   logic [63:0] wdata_sh;
   logic [63:0] merged;

   assign accept = (state_q == S_IDLE) && bus.req_valid;

   // Fault decision is taken on the raw request so no access is ever started
   // for a bad request.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      misalign = 1'b0;
      case (bus.req_funct3[1:0])
         2'b01:   misalign = bus.req_addr[0];
         2'b10:   misalign = |bus.req_addr[1:0];
         2'b11:   misalign = |bus.req_addr[2:0];
         default: misalign = 1'b0;
      endcase
      req_fault = (bus.req_addr >= ADDR_LIMIT)
                | misalign
                | (bus.req_write && bus.req_funct3[2])
                | (bus.req_funct3 == 3'b111);
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (req_fault)                         state_d = S_FLT;
               else if (!bus.req_write)               state_d = S_RD;
               else if (bus.req_funct3[1:0] == 2'b11) state_d = S_WR;
               else                                   state_d = S_RD;
            end
         end
         S_RD:    state_d = S_CAP;
         S_CAP:   state_d = write_q ? S_WR : S_RESP;
         S_WR:    state_d = S_RESP;
         S_FLT:   state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane extraction and extension for loads; readData is valid in CAP.
   always_comb begin
      lane     = bus.mem_readData >> {addr_q[2:0], 3'b000};
      load_val = 64'd0;
      case (funct3_q)
         3'b000:  load_val = {{56{lane[7]}},  lane[7:0]};
         3'b001:  load_val = {{48{lane[15]}}, lane[15:0]};
         3'b010:  load_val = {{32{lane[31]}}, lane[31:0]};
         3'b011:  load_val = lane;
         3'b100:  load_val = {56'd0, lane[7:0]};
         3'b101:  load_val = {48'd0, lane[15:0]};
         3'b110:  load_val = {32'd0, lane[31:0]};
         default: load_val = 64'd0;
      endcase
   end

   // Little-endian merge of store data into the doubleword read back in CAP.
   always_comb begin
      case (funct3_q[1:0])
         2'b00:   size_be = 8'h01;
         2'b01:   size_be = 8'h03;
         2'b10:   size_be = 8'h0F;
         default: size_be = 8'hFF;
      endcase
      byte_en  = size_be << addr_q[2:0];
      wdata_sh = wdata_q << {addr_q[2:0], 3'b000};
      merged   = 64'd0;
      for (int i = 0; i < 8; i++) begin
         merged[8*i +: 8] = byte_en[i] ? wdata_sh[8*i +: 8] : bus.mem_readData[8*i +: 8];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q   <= 64'd0;
         funct3_q <= 3'd0;
         write_q  <= 1'b0;
         wdata_q  <= 64'd0;
         rdata_q  <= 64'd0;
         fault_q  <= 1'b0;
      end else if (accept) begin
         addr_q   <= bus.req_addr;
         funct3_q <= bus.req_funct3;
         write_q  <= bus.req_write;
         wdata_q  <= bus.req_wdata;
         rdata_q  <= 64'd0;
         fault_q  <= req_fault;
      end else if (state_q == S_CAP) begin
         if (write_q) wdata_q <= merged;
         else         rdata_q <= load_val;
      end
   end

   // Outputs decode straight from state so the strobes drop the moment reset
   // is asserted, without waiting for a clock edge.
   assign bus.req_ready     = (state_q == S_IDLE);
   assign bus.resp_valid    = (state_q == S_RESP);
   assign bus.resp_rdata    = (state_q == S_RESP) ? rdata_q : 64'd0;
   assign bus.resp_fault    = (state_q == S_RESP) && fault_q;
   assign bus.mem_MemRead   = (state_q == S_RD);
   assign bus.mem_MemWrite  = (state_q == S_WR);
   assign bus.mem_address   = ((state_q == S_RD) || (state_q == S_WR)) ?
                              {addr_q[63:3], 3'b000} : 64'd0;
   assign bus.mem_writeData = (state_q == S_WR) ? wdata_q : 64'd0;

`ifdef LSU_STATS_EN
   logic [31:0] stat_loads_q, stat_stores_q, stat_faults_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_loads_q  <= 32'd0;
         stat_stores_q <= 32'd0;
         stat_faults_q <= 32'd0;
      end else if (state_q == S_RESP) begin
         if (fault_q) begin
            if (stat_faults_q != 32'hFFFF_FFFF) stat_faults_q <= stat_faults_q + 32'd1;
         end else if (write_q) begin
            if (stat_stores_q != 32'hFFFF_FFFF) stat_stores_q <= stat_stores_q + 32'd1;
         end else begin
            if (stat_loads_q != 32'hFFFF_FFFF)  stat_loads_q  <= stat_loads_q + 32'd1;
         end
      end
   end

   assign stat_loads  = stat_loads_q;
   assign stat_stores = stat_stores_q;
   assign stat_faults = stat_faults_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose: self-checking bench for load_store_unit. Requests are issued by a
// stimulus process that predicts each response from a byte-addressed reference
// memory and pushes it into a scoreboard queue; a negedge monitor pops and
// compares whenever resp_valid is seen, also checking latency, memory strobe
// counts and addresses. A behavioural 1-cycle memory sits on the memory bus.
// Build option: LSU_STATS_EN also checks the statistics counters.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam time T = 10;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #(T/2) clk = ~clk;

   load_store_unit_if bus();

`ifdef LSU_STATS_EN
   logic [31:0] stat_loads, stat_stores, stat_faults;
`endif

   load_store_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
`ifdef LSU_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_faults (stat_faults)
`endif
   );

   // ---------------- behavioural data memory ----------------
   function automatic logic [63:0] init_word(input int idx);
      logic [31:0] a, b;
      a = idx * 32'h9E37_79B1 ^ 32'h5BD1_E995;
      b = (~idx) * 32'h85EB_CA6B;
      return {a, b};
   endfunction

   logic [63:0] mem_arr [1024];
   bit          mem_wr  [1024];

   always @(posedge clk) begin
      if (bus.mem_MemWrite) begin
         mem_arr[bus.mem_address[12:3]] <= bus.mem_writeData;
         mem_wr[bus.mem_address[12:3]]  <= 1'b1;
      end
      if (bus.mem_MemRead)
         bus.mem_readData <= mem_wr[bus.mem_address[12:3]] ?
                             mem_arr[bus.mem_address[12:3]] :
                             init_word(int'(bus.mem_address[12:3]));
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [63:0] rdata;
      logic        fault;
      int          kind;    // 0 load, 1 store, 2 fault
      int          lat;
      int          nrd;
      int          nwr;
      logic [63:0] aaddr;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   logic [7:0] ref_mem [8192];

   int vectors     = 0;
   int miscompares = 0;
   int pcnt        = 0;
   int rd_cnt      = 0;
   int wr_cnt      = 0;
   int n_loads     = 0;
   int n_stores    = 0;
   int n_faults    = 0;
   bit mon_en      = 1'b1;

   always @(posedge clk) pcnt <= pcnt + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Reference model: byte-level memory and plain arithmetic on access size.
   task automatic predict(input logic w, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d, output exp_t e);
      int size;
      logic [63:0] val;
      size    = 1 << f3[1:0];
      e.aaddr = {a[63:3], 3'b000};
      e.acc   = 0;
      e.rdata = 64'd0;
      if (a >= 64'h2000 || (a % size) != 0 || (w && f3[2]) || f3 == 3'b111) begin
         e.fault = 1'b1; e.kind = 2; e.lat = 2; e.nrd = 0; e.nwr = 0;
      end else if (!w) begin
         val = 64'd0;
         for (int i = 0; i < size; i++)
            val = val | (64'(ref_mem[int'(a[12:0]) + i]) << (8 * i));
         if (!f3[2] && size < 8 && val[8*size-1])
            val = val | (~64'd0 << (8 * size));
         e.rdata = val;
         e.fault = 1'b0; e.kind = 0; e.lat = 3; e.nrd = 1; e.nwr = 0;
      end else begin
         for (int i = 0; i < size; i++)
            ref_mem[int'(a[12:0]) + i] = d[8*i +: 8];
         e.fault = 1'b0; e.kind = 1; e.nwr = 1;
         if (size == 8) begin e.lat = 2; e.nrd = 0; end
         else           begin e.lat = 4; e.nrd = 1; end
      end
   endtask

   // Drives one request; req_valid stays high afterwards until the caller
   // drops it, so back-to-back requests overlap the busy states.
   task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d);
      exp_t e;
      int   guard;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", 64'(bus.req_ready), 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      predict(w, f3, a, d, e);
      @(posedge clk);
      #1;
      e.acc = pcnt;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         rd_cnt   = 0;
         wr_cnt   = 0;
         n_loads  = 0;
         n_stores = 0;
         n_faults = 0;
      end else if (mon_en) begin
         if (exp_q.size() == 0) begin
            if (bus.mem_MemRead || bus.mem_MemWrite)
               check("spurious_strobe", 64'(bus.mem_MemRead | bus.mem_MemWrite), 64'd0);
            if (bus.resp_valid)
               check("spurious_resp", 64'(bus.resp_valid), 64'd0);
         end else begin
            check("ready_while_busy", 64'(bus.req_ready), 64'd0);
            if (bus.mem_MemRead || bus.mem_MemWrite)
               check("mem_address", bus.mem_address, exp_q[0].aaddr);
            if (bus.mem_MemRead)  rd_cnt++;
            if (bus.mem_MemWrite) wr_cnt++;
            if (bus.resp_valid) begin
               e = exp_q.pop_front();
               check("resp_rdata",  bus.resp_rdata, e.rdata);
               check("resp_fault",  64'(bus.resp_fault), 64'(e.fault));
               check("resp_latency", 64'(pcnt - e.acc + 1), 64'(e.lat));
               check("memread_cycles",  64'(rd_cnt), 64'(e.nrd));
               check("memwrite_cycles", 64'(wr_cnt), 64'(e.nwr));
               rd_cnt = 0;
               wr_cnt = 0;
               case (e.kind)
                  0:       n_loads++;
                  1:       n_stores++;
                  default: n_faults++;
               endcase
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] saved [8];
      int          guard;
      logic [63:0] a;
      logic [2:0]  f3;
      logic        w;

      for (int i = 0; i < 1024; i++) begin
         logic [63:0] iw;
         iw = init_word(i);
         for (int b = 0; b < 8; b++) ref_mem[8*i + b] = iw[8*b +: 8];
      end

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 64'd0;
      bus.req_wdata  = 64'd0;

      repeat (3) @(negedge clk);
      check("rst_req_ready",  64'(bus.req_ready), 64'd1);
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_rdata", bus.resp_rdata, 64'd0);
      check("rst_strobes",    64'({bus.mem_MemRead, bus.mem_MemWrite}), 64'd0);
      check("rst_mem_address", bus.mem_address, 64'd0);
      reset = 1'b1;

      // Directed sequence.
      issue(1'b1, 3'b011, 64'h10,   64'h1122_3344_5566_7788);  // SD
      issue(1'b0, 3'b011, 64'h10,   64'd0);                    // LD
      issue(1'b1, 3'b000, 64'h13,   64'h80);                   // SB
      issue(1'b0, 3'b011, 64'h10,   64'd0);                    // LD merged word
      issue(1'b0, 3'b000, 64'h13,   64'd0);                    // LB
      issue(1'b0, 3'b100, 64'h13,   64'd0);                    // LBU
      issue(1'b0, 3'b010, 64'h14,   64'd0);                    // LW
      issue(1'b0, 3'b001, 64'h11,   64'd0);                    // LH misaligned
      issue(1'b0, 3'b011, 64'h2000, 64'd0);                    // LD out of range
      issue(1'b1, 3'b100, 64'h10,   64'hAB);                   // illegal store
      issue(1'b0, 3'b111, 64'h10,   64'd0);                    // funct3 111
      issue(1'b1, 3'b001, 64'h1FFE, 64'hBEEF);                 // SH at top
      issue(1'b0, 3'b101, 64'h1FFE, 64'd0);                    // LHU
      issue(1'b0, 3'b001, 64'h1FFE, 64'd0);                    // LH
      issue(1'b0, 3'b011, 64'h1FF8, 64'd0);                    // LD whole word
      bus.req_valid = 1'b0;
      drain();

      // Reset during the WR cycle of an SW: the write must never land.
      for (int b = 0; b < 8; b++) saved[b] = 64'(ref_mem[16'h20 + b]);
      mon_en = 1'b0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 64'h24;
      bus.req_wdata  = 64'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      guard = 0;
      while (!bus.mem_MemWrite && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      check("sw_reached_wr", 64'(bus.mem_MemWrite), 64'd1);
      #1;
      reset = 1'b0;
      #1;
      check("async_memwrite_drop", 64'(bus.mem_MemWrite), 64'd0);
      check("async_memread_drop",  64'(bus.mem_MemRead), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(bus.req_ready), 64'd1);
      check("post_rst_resp",  64'(bus.resp_valid), 64'd0);
      for (int b = 0; b < 8; b++) ref_mem[16'h20 + b] = saved[b][7:0];
      mon_en = 1'b1;
      issue(1'b0, 3'b011, 64'h20, 64'd0);                      // word untouched
      bus.req_valid = 1'b0;
      drain();

      // Randomized traffic concentrated on a few words so loads see stores.
      for (int n = 0; n < 400; n++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 64'(($urandom_range(0, 7) * 8 + 16'h1FC0) + $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
         if ($urandom_range(0, 15) == 0) a = 64'h2000 + 64'($urandom_range(0, 64));
         if ($urandom_range(0, 31) == 0) a = {32'($urandom), 32'($urandom)};
         issue(w, f3, a, {32'($urandom), 32'($urandom)});
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      bus.req_valid = 1'b0;
      drain();

`ifdef LSU_STATS_EN
      @(negedge clk);
      check("stat_loads",  64'(stat_loads),  64'(n_loads));
      check("stat_stores", 64'(stat_stores), 64'(n_stores));
      check("stat_faults", 64'(stat_faults), 64'(n_faults));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
